// File: rtl/serial_rx_pkg.sv
// Shared types and helpers for the serial frame receiver.
package serial_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } state_t;

  // Half-bit count used to land the start-bit sample mid-bit.
  function automatic int half_bit(input int clks_per_bit);
    return clks_per_bit / 2;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous input.
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  // Resolve metastability over two stages; reset to the line's idle level.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= RST_VAL;
      r_q    <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/serial_rx.sv
// MSB-first serial frame receiver: start detect, mid-bit sampling,
// stop check and a valid/ready parallel output.
module serial_rx
  import serial_rx_pkg::*;
#(
  parameter int SIZE         = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic            SerIn,
  input  logic            Ready,
  output logic [SIZE-1:0] DataOut,
  output logic            Valid,
  output logic            FrameErr,
  output logic            Overrun,
  output logic            Busy
);

  localparam int H  = half_bit(CLKS_PER_BIT);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(SIZE + 1);

  localparam logic [CW-1:0] CNT_HALF = CW'(H - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(SIZE - 1);

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic [BW-1:0]   r_bit;
  logic [SIZE-1:0] r_shreg;
  logic            w_rx;
  logic            w_cnt_clr;
  logic            w_bit_clr;
  logic            w_shift;
  logic            w_stop;

  sync2 #(.RST_VAL(1'b1)) u_sync (
    .i_clk (Clk),
    .i_rst (Rst),
    .i_d   (SerIn),
    .o_q   (w_rx)
  );

  // State register.
  always_ff @(posedge Clk) begin
    if (Rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next-state and sampling strobes; every sample point is a counter match.
  always_comb begin
    w_next    = r_state;
    w_cnt_clr = 1'b0;
    w_bit_clr = 1'b0;
    w_shift   = 1'b0;
    w_stop    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (!w_rx) begin
          w_next    = ST_START;
          w_cnt_clr = 1'b1;
          w_bit_clr = 1'b1;
        end
      end
      ST_START: begin
        if (r_cnt == CNT_HALF) begin
          w_cnt_clr = 1'b1;
          // A start bit that is gone by mid-bit is line noise.
          w_next    = w_rx ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (r_cnt == CNT_FULL) begin
          w_cnt_clr = 1'b1;
          w_shift   = 1'b1;
          if (r_bit == BIT_LAST) w_next = ST_STOP;
        end
      end
      ST_STOP: begin
        if (r_cnt == CNT_FULL) begin
          w_stop = 1'b1;
          // A low stop bit may be a break; wait for the line to recover.
          w_next = w_rx ? ST_IDLE : ST_WAIT_HIGH;
        end
      end
      ST_WAIT_HIGH: begin
        if (w_rx) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Bit-timing counter, bit index and shift register.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shreg <= '0;
    end else begin
      if (w_cnt_clr)
        r_cnt <= '0;
      else if (r_state == ST_START || r_state == ST_DATA || r_state == ST_STOP)
        r_cnt <= r_cnt + CW'(1);
      if (w_bit_clr)
        r_bit <= '0;
      else if (w_shift)
        r_bit <= r_bit + BW'(1);
      if (w_shift)
        r_shreg <= {r_shreg[SIZE-2:0], w_rx};
    end
  end

  // Output word, handshake and one-cycle status pulses.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      DataOut  <= '0;
      Valid    <= 1'b0;
      FrameErr <= 1'b0;
      Overrun  <= 1'b0;
    end else begin
      FrameErr <= 1'b0;
      Overrun  <= 1'b0;
      if (Valid && Ready) Valid <= 1'b0;
      if (w_stop) begin
        if (w_rx) begin
          // Consumer freeing the slot this same cycle makes room for the new word.
          if (!Valid || Ready) begin
            DataOut <= r_shreg;
            Valid   <= 1'b1;
          end else begin
            Overrun <= 1'b1;
          end
        end else begin
          FrameErr <= 1'b1;
        end
      end
    end
  end

  assign Busy = (r_state != ST_IDLE);

endmodule

// File: tb/tb_serial_rx.sv
// Bench for serial_rx: directed frames, a timestamp-based frame model and
// per-cycle comparison of all outputs.
module tb_serial_rx;

  localparam int SIZE = 8;
  localparam int C    = 4;
  localparam int H    = C / 2;

  logic            Clk = 1'b0;
  logic            Rst = 1'b1;
  logic            SerIn = 1'b1;
  logic            Ready = 1'b0;
  logic [SIZE-1:0] DataOut;
  logic            Valid, FrameErr, Overrun, Busy;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  bit chk_en = 1'b0;

  serial_rx #(.SIZE(SIZE), .CLKS_PER_BIT(C)) dut (
    .Clk(Clk), .Rst(Rst), .SerIn(SerIn), .Ready(Ready),
    .DataOut(DataOut), .Valid(Valid), .FrameErr(FrameErr),
    .Overrun(Overrun), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  // Model: the line is delayed two cycles; a frame is decoded from the
  // elapsed time since the falling edge was seen.
  logic [SIZE-1:0] m_data = '0, m_word = '0;
  logic m_valid = 0, m_fe = 0, m_ov = 0, m_s1 = 1, m_s2 = 1;
  int   m_phase = 0;   // 0 idle, 1 in frame, 2 waiting for line high
  int   m_t0 = 0;

  always @(posedge Clk) begin : model
    logic rx, old;
    int d, k;
    cyc++;
    if (Rst) begin
      m_s1 = 1; m_s2 = 1; m_phase = 0; m_data = '0; m_valid = 0;
      m_fe = 0; m_ov = 0; m_word = '0;
    end else begin
      rx = m_s2; m_s2 = m_s1; m_s1 = SerIn;
      m_fe = 0; m_ov = 0;
      old = m_valid;
      if (old && Ready) m_valid = 0;
      case (m_phase)
        0: if (!rx) begin m_phase = 1; m_t0 = cyc; end
        1: begin
          d = cyc - m_t0;
          if (d == H) begin
            if (rx) m_phase = 0;
          end else if (d > H && (d - H) % C == 0) begin
            k = (d - H) / C;
            if (k <= SIZE) m_word = {m_word[SIZE-2:0], rx};
            else if (rx) begin
              if (!old || Ready) begin m_data = m_word; m_valid = 1; end
              else m_ov = 1;
              m_phase = 0;
            end else begin
              m_fe = 1; m_phase = 2;
            end
          end
        end
        default: if (rx) m_phase = 0;
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle comparison against the model, plus pulse tallies.
  always @(negedge Clk) begin
    if (chk_en) begin
      chk("DataOut", 32'(DataOut), 32'(m_data));
      chk("Valid", 32'(Valid), 32'(m_valid));
      chk("FrameErr", 32'(FrameErr), 32'(m_fe));
      chk("Overrun", 32'(Overrun), 32'(m_ov));
      chk("Busy", 32'(Busy), 32'(m_phase != 0));
      if (FrameErr === 1'b1) fe_cnt++;
      if (Overrun === 1'b1) ov_cnt++;
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge Clk); #1; end
  endtask

  task automatic hold(input logic v, input int n);
    SerIn = v;
    step(n);
  endtask

  task automatic send_frame(input logic [SIZE-1:0] d, input logic stop, output int e0);
    e0 = cyc;
    hold(1'b0, C);
    for (int i = SIZE - 1; i >= 0; i--) hold(d[i], C);
    hold(stop, C);
    SerIn = 1'b1;
  endtask

  task automatic wait_valid(input int e0, output int lat);
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      if (Valid === 1'b1) begin lat = cyc - e0; break; end
    end
    @(posedge Clk); #1;
  endtask

  task automatic consume();
    Ready = 1'b1; step(1); Ready = 1'b0;
  endtask

  initial begin
    int e0, e1, lat;
    step(3);
    Rst = 1'b0;
    chk_en = 1'b1;
    chk("rst_valid", 32'(Valid), 32'd0);
    chk("rst_data", 32'(DataOut), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    step(4);

    // Good frame, latency pinned: Valid first seen 41 edges after start drive.
    send_frame(8'hA5, 1'b1, e0);
    wait_valid(e0, lat);
    chk("a5_latency", 32'(lat), 32'd41);
    chk("a5_data", 32'(DataOut), 32'hA5);
    chk("a5_busy", 32'(Busy), 32'd0);
    step(5);
    chk("a5_hold", 32'(Valid), 32'd1);
    consume();
    chk("a5_consumed", 32'(Valid), 32'd0);
    step(4);

    // Start glitch.
    fe_cnt = 0; ov_cnt = 0;
    hold(1'b0, 1);
    hold(1'b1, 20);
    chk("glitch_busy", 32'(Busy), 32'd0);
    chk("glitch_valid", 32'(Valid), 32'd0);
    chk("glitch_pulses", 32'(fe_cnt + ov_cnt), 32'd0);

    // Bad stop bit followed by a break.
    send_frame(8'h3C, 1'b0, e0);
    SerIn = 1'b0;
    hold(1'b0, 20);
    chk("fe_count", 32'(fe_cnt), 32'd1);
    chk("fe_valid", 32'(Valid), 32'd0);
    chk("fe_wait_busy", 32'(Busy), 32'd1);
    hold(1'b1, 6);
    chk("fe_recover", 32'(Busy), 32'd0);
    send_frame(8'h81, 1'b1, e0);
    wait_valid(e0, lat);
    chk("x81_data", 32'(DataOut), 32'h81);
    consume();
    step(3);

    // Back-to-back with no consumer: second word overruns.
    ov_cnt = 0;
    send_frame(8'h12, 1'b1, e0);
    send_frame(8'h34, 1'b1, e1);
    step(6);
    chk("b2b_data", 32'(DataOut), 32'h12);
    chk("b2b_valid", 32'(Valid), 32'd1);
    chk("b2b_ov", 32'(ov_cnt), 32'd1);
    consume();
    step(3);

    // Ready coincides with the second frame's stop sample.
    ov_cnt = 0;
    send_frame(8'h12, 1'b1, e0);
    send_frame(8'h34, 1'b1, e1);
    consume();
    step(3);
    chk("sim_data", 32'(DataOut), 32'h34);
    chk("sim_valid", 32'(Valid), 32'd1);
    chk("sim_ov", 32'(ov_cnt), 32'd0);

    // Reset in the middle of a frame.
    fork
      send_frame(8'hFF, 1'b1, e0);
      begin
        step(17);
        Rst = 1'b1;
        step(1);
        chk("mid_rst_valid", 32'(Valid), 32'd0);
        chk("mid_rst_data", 32'(DataOut), 32'd0);
        chk("mid_rst_busy", 32'(Busy), 32'd0);
        Rst = 1'b0;
      end
    join
    step(5);
    chk("post_rst_idle", 32'(Busy), 32'd0);
    send_frame(8'h5A, 1'b1, e0);
    wait_valid(e0, lat);
    chk("x5a_latency", 32'(lat), 32'd41);
    chk("x5a_data", 32'(DataOut), 32'h5A);
    step(5);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/serial_rx.md
Name: serial_rx

Overview:
Serial frame receiver and deserializer, the receive end of the MSB-first serial link driven by the team's parallel-load shift register. It detects a start bit on an asynchronous serial line and samples SIZE data bits, MSB first, at mid-bit. It checks the stop bit and presents the assembled word on a parallel output with a valid/ready handshake. It sits between the serial pin and any parallel consumer, such as a FIFO or register file.

Parameters:
SIZE, 8, data bits per frame (>=2)
CLKS_PER_BIT, 16, Clk cycles per serial bit (>=4); H = CLKS_PER_BIT/2 (integer division)

Ports:
Clk  input  1  system clock, rising edge
Rst  input  1  reset, synchronous, active-high
SerIn  input  1  asynchronous serial line, idle high
Ready  input  1  consumer accepts DataOut when Valid&Ready
DataOut  output  SIZE  last good received word, MSB = first data bit
Valid  output  1  DataOut holds an unconsumed word
FrameErr  output  1  one-cycle pulse: stop bit sampled 0
Overrun  output  1  one-cycle pulse: good frame lost because Valid was still high
Busy  output  1  high in any state other than IDLE

Behaviour:
- One clock (Clk); reset is synchronous and active-high (Rst); no other reset.
- Reset values: DataOut=0, Valid=0, FrameErr=0, Overrun=0, Busy=0, state=IDLE, synchronizer flops=1, counters=0.
- Reset mid-frame drops the partial frame. Reset has priority over every other event.
- SerIn passes through a 2-FF synchronizer; the synchronized signal is called rx. All decisions use rx only.
- State IDLE:
  - On rx==0, go to START and clear the bit counter. Call this cycle T0.
- State START:
  - Count H cycles, then sample rx at cycle T0+H.
  - rx==0: go to DATA with the counter restarted.
  - rx==1: treat as a glitch, return to IDLE with no output pulse.
- State DATA:
  - Sample data bit i (i=0..SIZE-1) at T0+H+(i+1)*CLKS_PER_BIT.
  - Shift into the internal register: shreg <= {shreg[SIZE-2:0], rx}.
  - After bit SIZE-1, go to STOP.
- State STOP: sample rx at T0+H+(SIZE+1)*CLKS_PER_BIT.
  - rx==1, Valid==0 or Ready==1: next cycle DataOut<=shreg, Valid=1. Go to IDLE.
  - rx==1, Valid==1 and Ready==0: next cycle Overrun=1 for one cycle. DataOut and Valid are unchanged and the new word is discarded. Go to IDLE.
  - rx==0: next cycle FrameErr=1 for one cycle. The word is discarded, DataOut and Valid are untouched. Go to WAIT_HIGH.
- State WAIT_HIGH:
  - Stay until rx==1, then go to IDLE. This prevents a break condition from retriggering frames.
- Latency: Valid rises at cycle T0+H+(SIZE+1)*CLKS_PER_BIT+1. T0 is 2 cycles after SerIn falls, because of the synchronizer.
- Handshake:
  - Valid stays high and DataOut stays stable until a cycle with Valid&Ready; Valid clears on the next edge.
  - Ready while Valid==0 is ignored.
- Simultaneous events:
  - Ready consumes the old word in the same cycle a good stop is sampled: load the new word, keep Valid=1, no Overrun.
- Back-to-back frames:
  - IDLE may detect a new start in the cycle right after leaving STOP.
  - No minimum gap beyond one stop bit is required.
- Busy = (state != IDLE).
- Counter width: $clog2(CLKS_PER_BIT) bits. Bit index width: $clog2(SIZE+1) bits. No wrap-around inside a frame.

Decomposition:
- Package serial_rx_pkg holds:
  - state encoding constants ST_IDLE, ST_START, ST_DATA, ST_STOP, ST_WAIT_HIGH (3 bits);
  - localparam helper for the half-bit count.
- One sub-module, sync2: a 2-flop synchronizer with a reset value parameter (1 here). It is reusable for other asynchronous inputs.
- The FSM, bit-timing counter, shift register and output register all live in serial_rx.

Test Plan:
(All scenarios use SIZE=8, CLKS_PER_BIT=4.)
- Frame with data 0xA5, stop=1, Ready held 0: Valid rises at T0+39, DataOut=0xA5, Busy low afterwards. Pulse Ready for 1 cycle: Valid=0 next cycle.
- SerIn low for 1 cycle only, then high: returns to IDLE after the START sample; no Valid, FrameErr or Overrun.
- Frame 0x3C with stop bit 0: FrameErr pulses for exactly 1 cycle and Valid stays 0. Hold SerIn low 20 more cycles: no new frame. Then high, then frame 0x81: DataOut=0x81.
- Frames 0x12 then 0x34 back-to-back, Ready=0: DataOut=0x12, Valid=1, one Overrun pulse at the end of the second frame.
- Frames 0x12 then 0x34 with Ready asserted exactly in the second frame's stop-sample cycle: DataOut=0x34, Valid stays 1, no Overrun.
- Rst asserted for 1 cycle at T0+15 of frame 0xFF: all outputs 0, state IDLE. The next clean frame 0x5A is received correctly.
